// File: rtl/counter_run_pkg.sv
// Shared types and default widths for the counter run controller.
package counter_run_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CYC_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    SETTLE,
    DONE
  } state_t;

endpackage

// File: rtl/counter_run_watchdog.sv
// Saturating stall counter: counts stall cycles since the last clear and
// raises fire during the stall cycle that brings the count up to TIMEOUT.
module counter_run_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic fire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign fire = stall && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run sequencer for the counter datapath: load, enable for N cycles, capture.
// Optional done-stall watchdog enabled by `define COUNTER_RUN_CTRL_TIMEOUT_EN.
module counter_run_ctrl
  import counter_run_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CYC_W   = CYC_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic [CYC_W-1:0] cfg_cycles,
  input  logic             abort,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] done_value,
  output logic             done_wrapped,
  output logic             busy
`ifdef COUNTER_RUN_CTRL_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("counter_run_ctrl: TIMEOUT must be at least 1");
  end

  state_t           state;
  logic [CYC_W-1:0] remaining;
  logic [WIDTH-1:0] load_val;
  logic             wrap;
  logic             stall_fire;

`ifdef COUNTER_RUN_CTRL_TIMEOUT_EN
  counter_run_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock(clock),
    .reset(reset),
    .clear(state == SETTLE),
    .stall((state == DONE) && !done_ready),
    .fire (stall_fire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) timeout <= 1'b0;
    else        timeout <= stall_fire;
  end
`else
  assign stall_fire = 1'b0;
`endif

  // Abort gates the strobes directly so the counter stops in the abort cycle.
  assign start_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign cnt_load     = (state == LOAD) && !abort;
  assign cnt_en       = (state == RUN) && !abort;
  assign cnt_load_val = load_val;
  assign done_valid   = (state == DONE);

  // NOTE: all state here is plain flops updated with <=, so every branch
  // reads pre-edge values; there is no memory array, so everything is reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      remaining    <= '0;
      load_val     <= '0;
      wrap         <= 1'b0;
      done_value   <= '0;
      done_wrapped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            load_val  <= cfg_load;
            remaining <= cfg_cycles;
            wrap      <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (abort)                  state <= IDLE;
          else if (remaining == '0)   state <= SETTLE;
          else                        state <= RUN;
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            remaining <= remaining - 1'b1;
            if (cnt_value == '1)                wrap  <= 1'b1;
            if (remaining == CYC_W'(1))         state <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            // The counter's last enabled increment is visible one cycle late.
            done_value   <= cnt_value;
            done_wrapped <= wrap;
            state        <= DONE;
          end
        end
        DONE: begin
          if (done_ready || stall_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
